// File: rtl/ncc_search_ctrl.sv
// NCC template-search sequencer: streams the descriptor into the PE grid, then raster-scans
// window offsets with fetch/evaluate handshakes while tracking the best signed score.
module ncc_search_ctrl #(
    parameter int DESC_WORDS = 64,
    parameter int SEARCH_W   = 16,
    parameter int SEARCH_H   = 16,
    parameter int COORD_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    input  logic               desc_in_valid,
    output logic               desc_in_ready,
    input  logic [31:0]        desc_in_data,
    output logic [31:0]        ncc_desc_data,
    output logic               ncc_desc_ready,
    output logic               win_req,
    output logic [COORD_W-1:0] win_x,
    output logic [COORD_W-1:0] win_y,
    input  logic               win_ack,
    output logic               ncc_window_ready,
    input  logic               ncc_window_done,
    input  logic [31:0]        ncc_score,
    output logic [31:0]        best_score,
    output logic [COORD_W-1:0] best_x,
    output logic [COORD_W-1:0] best_y,
    output logic               result_valid
);

    localparam int          CNT_W     = $clog2(DESC_WORDS + 1);
    localparam logic [31:0] SCORE_MIN = 32'h8000_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DESC_FETCH,
        S_DESC_ISSUE,
        S_DESC_GAP,
        S_WIN_REQ,
        S_WIN_GO,
        S_WIN_WAIT,
        S_WIN_NEXT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [31:0]        r_desc_data;
    logic [31:0]        r_best_score;
    logic [COORD_W-1:0] r_best_x;
    logic [COORD_W-1:0] r_best_y;
    logic               w_start_go;
    logic               w_last_word;
    logic               w_last_x;
    logic               w_last_offset;
    logic               w_better;

    assign w_start_go    = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last_word   = (r_word_cnt == CNT_W'(DESC_WORDS - 1));
    assign w_last_x      = (r_x == COORD_W'(SEARCH_W - 1));
    assign w_last_offset = w_last_x && (r_y == COORD_W'(SEARCH_H - 1));
    // Strict signed compare: equal scores never displace an earlier raster position.
    assign w_better      = $signed(ncc_score) > $signed(r_best_score);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next           = r_state;
        busy             = 1'b1;
        desc_in_ready    = 1'b0;
        ncc_desc_ready   = 1'b0;
        win_req          = 1'b0;
        ncc_window_ready = 1'b0;
        result_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_DESC_FETCH;
            end
            S_DESC_FETCH: begin
                desc_in_ready = 1'b1;
                if (desc_in_valid) w_next = S_DESC_ISSUE;
            end
            S_DESC_ISSUE: begin
                ncc_desc_ready = 1'b1;
                w_next         = S_DESC_GAP;
            end
            S_DESC_GAP: begin
                w_next = w_last_word ? S_WIN_REQ : S_DESC_FETCH;
            end
            S_WIN_REQ: begin
                win_req = 1'b1;
                if (win_ack) w_next = S_WIN_GO;
            end
            S_WIN_GO: begin
                ncc_window_ready = 1'b1;
                w_next           = S_WIN_WAIT;
            end
            S_WIN_WAIT: begin
                if (ncc_window_done) w_next = S_WIN_NEXT;
            end
            S_WIN_NEXT: begin
                w_next = w_last_offset ? S_DONE : S_WIN_REQ;
            end
            S_DONE: begin
                busy         = 1'b0;
                result_valid = 1'b1;
                if (start) w_next = S_DESC_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt   <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_desc_data  <= '0;
            r_best_score <= SCORE_MIN;
            r_best_x     <= '0;
            r_best_y     <= '0;
        end else if (w_start_go) begin
            r_word_cnt   <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_best_score <= SCORE_MIN;
            r_best_x     <= '0;
            r_best_y     <= '0;
        end else if (!abort) begin
            case (r_state)
                S_DESC_FETCH: begin
                    if (desc_in_valid) r_desc_data <= desc_in_data;
                end
                S_DESC_GAP: begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
                S_WIN_WAIT: begin
                    if (ncc_window_done && w_better) begin
                        r_best_score <= ncc_score;
                        r_best_x     <= r_x;
                        r_best_y     <= r_y;
                    end
                end
                S_WIN_NEXT: begin
                    if (w_last_x) begin
                        r_x <= '0;
                        r_y <= r_y + COORD_W'(1);
                    end else begin
                        r_x <= r_x + COORD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ncc_desc_data = r_desc_data;
    assign win_x         = r_x;
    assign win_y         = r_y;
    assign best_score    = r_best_score;
    assign best_x        = r_best_x;
    assign best_y        = r_best_y;

endmodule

// File: tb/tb_ncc_search_ctrl.sv
// Directed bench for ncc_search_ctrl on a 4x4 search grid: descriptor streaming, scan timing,
// best-score tracking with ties, handshake latency, abort and reset recovery.
module tb_ncc_search_ctrl;

    localparam int COORD_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic               busy;
    logic               desc_in_valid;
    logic               desc_in_ready;
    logic [31:0]        desc_in_data;
    logic [31:0]        ncc_desc_data;
    logic               ncc_desc_ready;
    logic               win_req;
    logic [COORD_W-1:0] win_x;
    logic [COORD_W-1:0] win_y;
    logic               win_ack;
    logic               ncc_window_ready;
    logic               ncc_window_done;
    logic [31:0]        ncc_score;
    logic [31:0]        best_score;
    logic [COORD_W-1:0] best_x;
    logic [COORD_W-1:0] best_y;
    logic               result_valid;

    ncc_search_ctrl #(
        .DESC_WORDS(64),
        .SEARCH_W  (4),
        .SEARCH_H  (4),
        .COORD_W   (COORD_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .busy            (busy),
        .desc_in_valid   (desc_in_valid),
        .desc_in_ready   (desc_in_ready),
        .desc_in_data    (desc_in_data),
        .ncc_desc_data   (ncc_desc_data),
        .ncc_desc_ready  (ncc_desc_ready),
        .win_req         (win_req),
        .win_x           (win_x),
        .win_y           (win_y),
        .win_ack         (win_ack),
        .ncc_window_ready(ncc_window_ready),
        .ncc_window_done (ncc_window_done),
        .ncc_score       (ncc_score),
        .best_score      (best_score),
        .best_x          (best_x),
        .best_y          (best_y),
        .result_valid    (result_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] desc_word(input int i);
        return 32'hC0DE_0000 + (32'(i) * 32'h0001_0003);
    endfunction

    // Upstream descriptor source: advances one word per accepted handshake.
    int feed_idx = 0;
    always @(posedge clk) begin
        if (rst || start) feed_idx <= 0;
        else if (desc_in_valid && desc_in_ready) feed_idx <= feed_idx + 1;
    end
    assign desc_in_data = desc_word(feed_idx);

    // Window fetch / evaluate responders with programmable latency.
    int   ack_lat = 0;
    int   done_lat = 0;
    int   req_cycles = 0;
    int   wait_cnt = 0;
    logic waiting = 1'b0;
    logic signed [31:0] score_tab [16];

    always @(posedge clk) begin
        req_cycles <= win_req ? req_cycles + 1 : 0;
        if (rst) begin
            waiting <= 1'b0;
        end else if (ncc_window_ready) begin
            waiting  <= 1'b1;
            wait_cnt <= 0;
        end else if (waiting) begin
            if (ncc_window_done) waiting <= 1'b0;
            wait_cnt <= wait_cnt + 1;
        end
    end
    assign win_ack         = win_req && (req_cycles >= ack_lat);
    assign ncc_window_done = waiting && (wait_cnt >= done_lat);
    assign ncc_score       = score_tab[{win_y[1:0], win_x[1:0]}];

    // Protocol monitor, sampled on the falling edge.
    int             cyc = 0;
    int             desc_pulses = 0;
    int             win_pulses = 0;
    int             last_desc_cyc = 0;
    int             strobe_err = 0;
    int             stable_err = 0;
    logic           prev_desc = 1'b0;
    logic           prev_win = 1'b0;
    logic           prev_req = 1'b0;
    logic [COORD_W-1:0] prev_x = '0;
    logic [COORD_W-1:0] prev_y = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ncc_desc_ready) begin
            check("desc_data", ncc_desc_data, desc_word(desc_pulses));
            if (desc_pulses > 0) check("desc_gap", cyc - last_desc_cyc, 3);
            last_desc_cyc = cyc;
            desc_pulses++;
        end
        if (ncc_window_ready) win_pulses++;
        if ((ncc_desc_ready && ncc_window_ready) || (prev_desc && ncc_desc_ready) ||
            (prev_win && ncc_window_ready))
            strobe_err++;
        if (win_req && prev_req && (win_x != prev_x || win_y != prev_y)) stable_err++;
        prev_desc = ncc_desc_ready;
        prev_win  = ncc_window_ready;
        prev_req  = win_req;
        prev_x    = win_x;
        prev_y    = win_y;
    end

    task automatic set_ramp();
        for (int i = 0; i < 16; i++) score_tab[i] = 32'(10 * (i / 4) + (i % 4));
    endtask

    task automatic set_tie();
        for (int i = 0; i < 16; i++) score_tab[i] = -32'sd5;
        score_tab[2*4+1] = 32'sd7;
        score_tab[2*4+2] = 32'sd7;
    endtask

    task automatic pulse_start();
        desc_pulses = 0;
        win_pulses  = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the first falling edge after the start edge; n counts falling edges from there.
    task automatic wait_done(input bit poke, output int n_done, output int n_req);
        n_req  = -1;
        n_done = -1;
        for (int n = 1; n < 4000; n++) begin
            if (n_req < 0 && win_req) n_req = n;
            if (result_valid) begin
                n_done = n;
                break;
            end
            start = (poke && n_req > 0 && n == n_req + 30);
            @(negedge clk);
        end
        start = 1'b0;
        check("result_valid", result_valid, 1);
    endtask

    task automatic check_best(input string tag, input logic [31:0] s, input int x, input int y);
        check({tag, "_score"}, best_score, s);
        check({tag, "_x"}, best_x, x);
        check({tag, "_y"}, best_y, y);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int n_done;
    int n_req;
    int snap;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        desc_in_valid = 1'b0;
        set_ramp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_desc_ready", desc_in_ready, 0);
        check("rst_desc_data", ncc_desc_data, 0);
        check("rst_desc_strobe", ncc_desc_ready, 0);
        check("rst_win_req", win_req, 0);
        check("rst_win_xy", {win_x, win_y}, 0);
        check("rst_win_strobe", ncc_window_ready, 0);
        check_best("rst_best", 32'h8000_0000, 0, 0);
        check("rst_result", result_valid, 0);

        // Ramp scores, zero-latency handshakes.
        desc_in_valid = 1'b1;
        pulse_start();
        wait_done(1'b0, n_done, n_req);
        check("a_done_cycle", n_done, 257);
        check("a_scan_cycles", n_done - n_req, 64);
        check("a_desc_pulses", desc_pulses, 64);
        check("a_win_pulses", win_pulses, 16);
        check_best("a_best", 33, 3, 3);
        check("a_busy", busy, 0);

        // Ties: the first 7 in raster order wins; signed compare against -5.
        set_tie();
        pulse_start();
        wait_done(1'b0, n_done, n_req);
        check_best("tie_best", 7, 1, 2);

        // Slow handshakes plus a start pulse mid-scan that must be ignored.
        set_ramp();
        ack_lat = 5;
        done_lat = 9;
        stable_err = 0;
        pulse_start();
        wait_done(1'b1, n_done, n_req);
        check("slow_scan_cycles", n_done - n_req, 288);
        check("slow_xy_stable", stable_err, 0);
        check("slow_win_pulses", win_pulses, 16);
        check_best("slow_best", 33, 3, 3);

        // Abort while requesting offset (2,1).
        ack_lat = 0;
        done_lat = 0;
        pulse_start();
        for (int n = 0; n < 2000 && !(win_req && win_x == 2 && win_y == 1); n++) @(negedge clk);
        check("abort_reach", {win_req, win_x, win_y}, {1'b1, 8'd2, 8'd1});
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_result", result_valid, 0);
        check("abort_strobes", {win_req, ncc_window_ready, ncc_desc_ready}, 0);
        check_best("abort_best", 11, 1, 1);
        repeat (3) @(negedge clk);
        check("abort_stay_idle", busy, 0);

        pulse_start();
        wait_done(1'b0, n_done, n_req);
        check("restart_done_cycle", n_done, 257);
        check_best("restart_best", 33, 3, 3);

        // Reset mid-scan clears the best-so-far.
        pulse_start();
        for (int n = 0; n < 2000 && !(win_req && win_y == 2); n++) @(negedge clk);
        check("mscan_reach", best_x, 3);
        pulse_rst();
        check_best("mscan_rst", 32'h8000_0000, 0, 0);
        check("mscan_rst_xy", {win_x, win_y}, 0);
        check("mscan_rst_busy", busy, 0);

        // Reset mid-descriptor: no further words are issued.
        pulse_start();
        for (int n = 0; n < 2000 && desc_pulses < 20; n++) @(negedge clk);
        check("mdesc_reach", desc_pulses >= 20, 1);
        pulse_rst();
        snap = desc_pulses;
        check("mdesc_rst_data", ncc_desc_data, 0);
        check("mdesc_rst_ready", desc_in_ready, 0);
        check("mdesc_rst_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("mdesc_no_reissue", desc_pulses, snap);
        check("mdesc_idle", {busy, result_valid}, 0);

        check("strobe_rules", strobe_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
